// File: rtl/lcd_8080_sink.sv
// lcd_8080_sink: panel-side responder for an 8-bit 8080-style LCD bus.
// Samples the asynchronous bus through a synchronizer and decodes the
// ILI9486 command subset: soft reset, MADCTL, COLMOD, CASET, PASET, RAMWR.
// RAMWR data is assembled into RGB565 pixels, which leave on a framebuffer
// write port. Decoded state is readable on the a/spo status port.
module lcd_8080_sink #(
    parameter int WIDTH       = 480,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  lcd_d,
    input  logic        lcd_wr,
    input  logic        lcd_rs,
    input  logic        lcd_cs,
    input  logic [31:0] a,
    output logic [31:0] spo,
    output logic        pix_we,
    output logic [17:0] pix_a,
    output logic [15:0] pix_d,
    output logic        frame_done
);

    localparam logic [15:0] COL_END = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_END = 16'(HEIGHT - 1);
    localparam logic [15:0] W16     = 16'(WIDTH);
    localparam logic [15:0] H16     = 16'(HEIGHT);
    localparam logic [17:0] W18     = 18'(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PARAM1 = 3'd1,
        ST_CAS    = 3'd2,
        ST_PAS    = 3'd3,
        ST_RAMWR  = 3'd4,
        ST_SKIP   = 3'd5
    } state_t;

    // Synchronizer chains: all bus lines share the same stages so that a
    // byte and its rs/cs qualifiers arrive at the decoder together.
    logic [SYNC_STAGES-1:0]       wr_sync_q;
    logic [SYNC_STAGES-1:0]       cs_sync_q;
    logic [SYNC_STAGES-1:0]       rs_sync_q;
    logic [SYNC_STAGES-1:0][7:0]  d_sync_q;
    logic                         wr_prev_q;

    // Decoder state
    state_t      state_q;
    logic [15:0] sc_q, ec_q, sp_q, ep_q;
    logic [7:0]  madctl_q, colmod_q, last_cmd_q;
    logic [31:0] pix_cnt_q;
    logic [15:0] col_q, row_q;
    logic        phase_q;
    logic [7:0]  hi_q;
    logic [2:0]  pcnt_q;
    logic [15:0] start_tmp_q;
    logic [7:0]  end_hi_q;
    logic        pix_we_q, frame_done_q;
    logic [17:0] pix_a_q;
    logic [15:0] pix_d_q;

    // Combinational helpers
    logic        byte_evt_s;
    logic        is_data_s;
    logic [7:0]  byte_s;
    logic [15:0] col_d, row_d;
    logic        wrap_s;
    logic        in_range_s;
    logic [17:0] pix_addr_s;
    logic [15:0] new_end_s;
    logic        commit_ok_s;
    logic        unused_a_s;

    assign unused_a_s = ^{a[31:4], a[1:0]};

    // Shift raw bus lines through the synchronizer; idle bus is wr=1, cs=1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sync_q <= '1;
            cs_sync_q <= '1;
            rs_sync_q <= '0;
            d_sync_q  <= '0;
            wr_prev_q <= 1'b1;
        end else begin
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], lcd_wr};
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], lcd_cs};
            rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
            d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], lcd_d};
            wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
        end
    end

    assign byte_evt_s = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    assign is_data_s  = rs_sync_q[SYNC_STAGES-1];
    assign byte_s     = d_sync_q[SYNC_STAGES-1];

    // Next cursor position, window wrap detection and pixel address
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        wrap_s = 1'b0;
        if (col_q == ec_q) begin
            col_d = sc_q;
            if (row_q == ep_q) begin
                row_d  = sp_q;
                wrap_s = 1'b1;
            end else begin
                row_d = row_q + 16'd1;
            end
        end else begin
            col_d = col_q + 16'd1;
        end
        in_range_s  = (col_q < W16) && (row_q < H16);
        pix_addr_s  = 18'(row_q) * W18 + 18'(col_q);
        new_end_s   = {end_hi_q, byte_s};
        commit_ok_s = (start_tmp_q <= new_end_s);
    end

    // Command/data decoder FSM with registered pixel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sc_q         <= 16'd0;
            ec_q         <= COL_END;
            sp_q         <= 16'd0;
            ep_q         <= ROW_END;
            madctl_q     <= 8'd0;
            colmod_q     <= 8'd0;
            last_cmd_q   <= 8'd0;
            pix_cnt_q    <= 32'd0;
            col_q        <= 16'd0;
            row_q        <= 16'd0;
            phase_q      <= 1'b0;
            hi_q         <= 8'd0;
            pcnt_q       <= 3'd0;
            start_tmp_q  <= 16'd0;
            end_hi_q     <= 8'd0;
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            pix_a_q      <= 18'd0;
            pix_d_q      <= 16'd0;
        end else begin
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            if (byte_evt_s) begin
                if (!is_data_s) begin
                    // Any command aborts pending pixel halves and parameters
                    last_cmd_q <= byte_s;
                    phase_q    <= 1'b0;
                    pcnt_q     <= 3'd0;
                    case (byte_s)
                        8'h01: begin
                            sc_q      <= 16'd0;
                            ec_q      <= COL_END;
                            sp_q      <= 16'd0;
                            ep_q      <= ROW_END;
                            madctl_q  <= 8'd0;
                            colmod_q  <= 8'd0;
                            pix_cnt_q <= 32'd0;
                            state_q   <= ST_SKIP;
                        end
                        8'h36, 8'h3A: state_q <= ST_PARAM1;
                        8'h2A:        state_q <= ST_CAS;
                        8'h2B:        state_q <= ST_PAS;
                        8'h2C: begin
                            col_q   <= sc_q;
                            row_q   <= sp_q;
                            state_q <= ST_RAMWR;
                        end
                        default:      state_q <= ST_SKIP;
                    endcase
                end else begin
                    case (state_q)
                        ST_PARAM1: begin
                            if (last_cmd_q == 8'h36) begin
                                madctl_q <= byte_s;
                            end else begin
                                colmod_q <= byte_s;
                            end
                            state_q <= ST_SKIP;
                        end
                        ST_CAS, ST_PAS: begin
                            case (pcnt_q)
                                3'd0: start_tmp_q[15:8] <= byte_s;
                                3'd1: start_tmp_q[7:0]  <= byte_s;
                                3'd2: end_hi_q          <= byte_s;
                                3'd3: begin
                                    // Reversed windows are rejected outright
                                    if (commit_ok_s) begin
                                        if (state_q == ST_CAS) begin
                                            sc_q <= start_tmp_q;
                                            ec_q <= new_end_s;
                                        end else begin
                                            sp_q <= start_tmp_q;
                                            ep_q <= new_end_s;
                                        end
                                    end else begin
                                        sc_q <= sc_q;
                                    end
                                end
                                default: pcnt_q <= pcnt_q;
                            endcase
                            if (pcnt_q != 3'd4) begin
                                pcnt_q <= pcnt_q + 3'd1;
                            end else begin
                                pcnt_q <= pcnt_q;
                            end
                        end
                        ST_RAMWR: begin
                            if (!phase_q) begin
                                hi_q    <= byte_s;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                // Off-panel pixels are dropped but still move the cursor
                                if (in_range_s) begin
                                    pix_we_q  <= 1'b1;
                                    pix_a_q   <= pix_addr_s;
                                    pix_d_q   <= {hi_q, byte_s};
                                    pix_cnt_q <= pix_cnt_q + 32'd1;
                                end else begin
                                    pix_we_q  <= 1'b0;
                                end
                                col_q        <= col_d;
                                row_q        <= row_d;
                                frame_done_q <= wrap_s;
                            end
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end else begin
                state_q <= state_q;
            end
        end
    end

    // Status read mux, combinational from registers
    always_comb begin
        spo = 32'd0;
        case (a[3:2])
            2'd0:    spo = {sc_q, ec_q};
            2'd1:    spo = {sp_q, ep_q};
            2'd2:    spo = {8'h00, madctl_q, colmod_q, last_cmd_q};
            2'd3:    spo = pix_cnt_q;
            default: spo = 32'd0;
        endcase
    end

    assign pix_we     = pix_we_q;
    assign pix_a      = pix_a_q;
    assign pix_d      = pix_d_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_8080_sink.sv
// Directed self-checking bench for lcd_8080_sink.
module tb_lcd_8080_sink;

    logic        clk;
    logic        rst;
    logic [7:0]  lcd_d;
    logic        lcd_wr;
    logic        lcd_rs;
    logic        lcd_cs;
    logic [31:0] a;
    logic [31:0] spo;
    logic        pix_we;
    logic [17:0] pix_a;
    logic [15:0] pix_d;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    int addr_q[$];
    int data_q[$];
    int fd_q[$];
    int fd_cnt = 0;

    lcd_8080_sink #(.WIDTH(480), .HEIGHT(320), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_d      (lcd_d),
        .lcd_wr     (lcd_wr),
        .lcd_rs     (lcd_rs),
        .lcd_cs     (lcd_cs),
        .a          (a),
        .spo        (spo),
        .pix_we     (pix_we),
        .pix_a      (pix_a),
        .pix_d      (pix_d),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture the pixel port away from the active edge
    always @(negedge clk) begin
        if (pix_we) begin
            addr_q.push_back(int'(pix_a));
            data_q.push_back(int'(pix_d));
            fd_q.push_back(int'(frame_done));
        end
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input logic cs);
        @(negedge clk);
        lcd_d  = d;
        lcd_rs = rs;
        lcd_cs = cs;
        lcd_wr = 1'b0;
        repeat (4) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] d);
        send(1'b0, d, 1'b0);
    endtask

    task automatic dat(input logic [7:0] d);
        send(1'b1, d, 1'b0);
    endtask

    task automatic chk_spo(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check_eq(tag, spo, exp);
    endtask

    task automatic clr_cap();
        addr_q.delete();
        data_q.delete();
        fd_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        int exp_a[3];
        int exp_d[3];
        exp_a = '{2410, 2411, 2412};
        exp_d = '{32'hF800, 32'h07E0, 32'h001F};

        rst    = 1'b1;
        lcd_d  = 8'h00;
        lcd_wr = 1'b1;
        lcd_rs = 1'b0;
        lcd_cs = 1'b1;
        a      = 32'd0;

        // Reset readback
        repeat (3) @(negedge clk);
        chk_spo("rst_win_col", 32'd0,  32'h000001DF);
        chk_spo("rst_win_row", 32'd4,  32'h0000013F);
        chk_spo("rst_regs",    32'd8,  32'h00000000);
        chk_spo("rst_count",   32'd12, 32'h00000000);
        check_eq("rst_pix_we", {31'd0, pix_we}, 32'd0);
        check_eq("rst_pix_a",  {14'd0, pix_a}, 32'd0);
        check_eq("rst_pix_d",  {16'd0, pix_d}, 32'd0);
        check_eq("rst_fd",     {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Window fill: cols 10..12 on row 5
        clr_cap();
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h05);
        cmd(8'h2C);
        dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0); dat(8'h00); dat(8'h1F);
        check_eq("fill_npix", addr_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < addr_q.size()) begin
                check_eq($sformatf("fill_a%0d", i), addr_q[i], exp_a[i]);
                check_eq($sformatf("fill_d%0d", i), data_q[i], exp_d[i]);
                check_eq($sformatf("fill_fd%0d", i), fd_q[i], (i == 2) ? 32'd1 : 32'd0);
            end
        end
        check_eq("fill_fd_cnt", fd_cnt, 32'd1);
        check_eq("fill_hold_a", {14'd0, pix_a}, 32'd2412);
        check_eq("fill_hold_d", {16'd0, pix_d}, 32'h001F);
        chk_spo("fill_col",   32'd0,  32'h000A000C);
        chk_spo("fill_row",   32'd4,  32'h00050005);
        chk_spo("fill_regs",  32'd8,  32'h0000002C);
        chk_spo("fill_count", 32'd12, 32'd3);

        // Odd-byte abort: stray high byte is discarded by the new RAMWR
        clr_cap();
        cmd(8'h2C); dat(8'hAB); cmd(8'h2C); dat(8'h12); dat(8'h34);
        check_eq("abort_npix", addr_q.size(), 32'd1);
        if (addr_q.size() > 0) begin
            check_eq("abort_a", addr_q[0], 32'd2410);
            check_eq("abort_d", data_q[0], 32'h1234);
        end
        check_eq("abort_fd", fd_cnt, 32'd0);
        chk_spo("abort_count", 32'd12, 32'd4);

        // MADCTL / COLMOD, extra parameter ignored
        cmd(8'h36); dat(8'h48); cmd(8'h3A); dat(8'h55); dat(8'h77);
        chk_spo("param_regs", 32'd8, 32'h0048553A);

        // Short and reversed CAS leave the window alone
        cmd(8'h2A); dat(8'h00); dat(8'h01); dat(8'h00); cmd(8'h2C);
        chk_spo("short_cas", 32'd0, 32'h000A000C);
        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h05);
        chk_spo("bad_cas",  32'd0, 32'h000A000C);
        chk_spo("bad_regs", 32'd8, 32'h0048552A);

        // Deselected bus is ignored
        send(1'b0, 8'h01, 1'b1);
        send(1'b0, 8'h2A, 1'b1);
        send(1'b1, 8'h00, 1'b1); send(1'b1, 8'h00, 1'b1);
        send(1'b1, 8'h00, 1'b1); send(1'b1, 8'h01, 1'b1);
        chk_spo("cs_col",  32'd0, 32'h000A000C);
        chk_spo("cs_regs", 32'd8, 32'h0048552A);

        // Window straddling the right panel edge: col 480 is dropped
        clr_cap();
        cmd(8'h2A); dat(8'h01); dat(8'hDF); dat(8'h01); dat(8'hE0);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
        cmd(8'h2C);
        dat(8'h11); dat(8'h22); dat(8'h33); dat(8'h44); dat(8'h55); dat(8'h66);
        chk_spo("oor_col", 32'd0, 32'h01DF01E0);
        check_eq("oor_npix", addr_q.size(), 32'd2);
        if (addr_q.size() > 1) begin
            check_eq("oor_a0", addr_q[0], 32'd479);
            check_eq("oor_d0", data_q[0], 32'h1122);
            check_eq("oor_a1", addr_q[1], 32'd479);
            check_eq("oor_d1", data_q[1], 32'h5566);
        end
        check_eq("oor_fd", fd_cnt, 32'd1);
        chk_spo("oor_count", 32'd12, 32'd6);

        // Async reset between the two bytes of a pixel
        clr_cap();
        cmd(8'h2C); dat(8'h99);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_we", {31'd0, pix_we}, 32'd0);
        chk_spo("arst_col", 32'd0, 32'h000001DF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dat(8'h88); dat(8'h01); dat(8'h02);
        check_eq("arst_npix", addr_q.size(), 32'd0);
        chk_spo("arst_count", 32'd12, 32'd0);

        // New RAMWR after reset, with latency of the completing byte
        cmd(8'h2C); dat(8'h05);
        @(negedge clk);
        lcd_d  = 8'h06;
        lcd_rs = 1'b1;
        lcd_cs = 1'b0;
        lcd_wr = 1'b0;
        repeat (4) @(negedge clk);
        lcd_wr = 1'b1;
        @(negedge clk);
        check_eq("lat_e0", {31'd0, pix_we}, 32'd0);
        @(negedge clk);
        check_eq("lat_e1", {31'd0, pix_we}, 32'd0);
        @(negedge clk);
        check_eq("lat_e2", {31'd0, pix_we}, 32'd1);
        check_eq("lat_a",  {14'd0, pix_a}, 32'd0);
        check_eq("lat_d",  {16'd0, pix_d}, 32'h0506);
        @(negedge clk);
        check_eq("lat_e3", {31'd0, pix_we}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("post_npix", addr_q.size(), 32'd1);
        chk_spo("post_count", 32'd12, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
